// File: rtl/cpu_decode_pkg.sv
// mox125 decode: form encodings, opcode names and per-opcode
// length and register-usage tables. Illegal detection: CPU_DECODE_ILLEGAL_TRAP_EN.
package cpu_decode_pkg;

  localparam logic [1:0] FORM1 = 2'd0;
  localparam logic [1:0] FORM2 = 2'd2;
  localparam logic [1:0] FORM3 = 2'd3;

  localparam logic [1:0] F2_INC = 2'd0;
  localparam logic [1:0] F2_DEC = 2'd1;
  localparam logic [1:0] F2_GSR = 2'd2;
  localparam logic [1:0] F2_SSR = 2'd3;

  typedef struct packed {
    logic rd_a;
    logic rd_b;
    logic wr_a;
  } use_t;

  localparam logic [7:0] LDI_L  = 8'h01;
  localparam logic [7:0] MOV    = 8'h02;
  localparam logic [7:0] JSRA   = 8'h03;
  localparam logic [7:0] RET    = 8'h04;
  localparam logic [7:0] ADD_L  = 8'h05;
  localparam logic [7:0] PUSH   = 8'h06;
  localparam logic [7:0] POP    = 8'h07;
  localparam logic [7:0] LDA_L  = 8'h08;
  localparam logic [7:0] STA_L  = 8'h09;
  localparam logic [7:0] LD_L   = 8'h0a;
  localparam logic [7:0] ST_L   = 8'h0b;
  localparam logic [7:0] LDO_L  = 8'h0c;
  localparam logic [7:0] STO_L  = 8'h0d;
  localparam logic [7:0] CMP    = 8'h0e;
  localparam logic [7:0] NOP    = 8'h0f;
  localparam logic [7:0] SEX_B  = 8'h10;
  localparam logic [7:0] SEX_S  = 8'h11;
  localparam logic [7:0] ZEX_B  = 8'h12;
  localparam logic [7:0] ZEX_S  = 8'h13;
  localparam logic [7:0] UMUL_X = 8'h14;
  localparam logic [7:0] MUL_X  = 8'h15;
  localparam logic [7:0] JSR    = 8'h19;
  localparam logic [7:0] JMPA   = 8'h1a;
  localparam logic [7:0] LDI_B  = 8'h1b;
  localparam logic [7:0] LD_B   = 8'h1c;
  localparam logic [7:0] LDA_B  = 8'h1d;
  localparam logic [7:0] ST_B   = 8'h1e;
  localparam logic [7:0] STA_B  = 8'h1f;
  localparam logic [7:0] LDI_S  = 8'h20;
  localparam logic [7:0] LD_S   = 8'h21;
  localparam logic [7:0] LDA_S  = 8'h22;
  localparam logic [7:0] ST_S   = 8'h23;
  localparam logic [7:0] STA_S  = 8'h24;
  localparam logic [7:0] JMP    = 8'h25;
  localparam logic [7:0] AND    = 8'h26;
  localparam logic [7:0] LSHR   = 8'h27;
  localparam logic [7:0] ASHL   = 8'h28;
  localparam logic [7:0] SUB_L  = 8'h29;
  localparam logic [7:0] NEG    = 8'h2a;
  localparam logic [7:0] OR     = 8'h2b;
  localparam logic [7:0] NOT    = 8'h2c;
  localparam logic [7:0] ASHR   = 8'h2d;
  localparam logic [7:0] XOR    = 8'h2e;
  localparam logic [7:0] MUL_L  = 8'h2f;
  localparam logic [7:0] SWI    = 8'h30;
  localparam logic [7:0] DIV_L  = 8'h31;
  localparam logic [7:0] UDIV_L = 8'h32;
  localparam logic [7:0] MOD_L  = 8'h33;
  localparam logic [7:0] UMOD_L = 8'h34;
  localparam logic [7:0] BRK    = 8'h35;
  localparam logic [7:0] LDO_B  = 8'h36;
  localparam logic [7:0] STO_B  = 8'h37;
  localparam logic [7:0] LDO_S  = 8'h38;
  localparam logic [7:0] STO_S  = 8'h39;

  function automatic logic [1:0] insn_form(
    input logic [15:0] op
  );
    return op[15] ? op[15:14] : FORM1;
  endfunction

  function automatic logic [2:0] insn_len(
    input logic [15:0] op
  );
    logic [2:0] len;
    case (op[15:8])
      LDI_L, JSRA, LDA_L, STA_L,
      JMPA, LDI_B, LDA_B, STA_B,
      LDI_S, LDA_S, STA_S, JMP,
      SWI:     len = 3'd6;
      LDO_L, STO_L, LDO_B,
      STO_B, LDO_S, STO_S:
               len = 3'd4;
      default: len = 3'd2;
    endcase
    return len;
  endfunction

  // Form3 and unlisted opcodes touch no scoreboarded register.
  function automatic use_t classify(
    input logic [15:0] op
  );
    use_t u;
    u = '0;
    if (op[15:14] == 2'b10) begin
      case (op[13:12])
        F2_INC, F2_DEC: u = '{1'b1, 1'b0, 1'b1};
        F2_GSR:         u = '{1'b0, 1'b0, 1'b1};
        default:        u = '{1'b1, 1'b0, 1'b0};
      endcase
    end else if (!op[15]) begin
      case (op[15:8])
        LDI_L, LDA_L, LDI_B,
        LDA_B, LDI_S, LDA_S:
          u = '{1'b0, 1'b0, 1'b1};
        MOV, LD_L, LDO_L, SEX_B,
        SEX_S, ZEX_B, ZEX_S, LD_B,
        LD_S, NEG, NOT, LDO_B, LDO_S:
          u = '{1'b0, 1'b1, 1'b1};
        STA_L, JSR, STA_B, STA_S, JMP:
          u = '{1'b1, 1'b0, 1'b0};
        ST_L, STO_L, CMP, ST_B,
        ST_S, STO_B, STO_S:
          u = '{1'b1, 1'b1, 1'b0};
        ADD_L, PUSH, UMUL_X, MUL_X,
        AND, LSHR, ASHL, SUB_L, OR,
        ASHR, XOR, MUL_L, DIV_L,
        UDIV_L, MOD_L, UMOD_L:
          u = '{1'b1, 1'b1, 1'b1};
        POP:
          u = '{1'b1, 1'b0, 1'b1};
        default:
          u = '0;
      endcase
    end
    return u;
  endfunction

  function automatic logic reads_a(
    input logic [15:0] op
  );
    use_t u;
    u = classify(op);
    return u.rd_a;
  endfunction

  function automatic logic reads_b(
    input logic [15:0] op
  );
    use_t u;
    u = classify(op);
    return u.rd_b;
  endfunction

  function automatic logic writes_a(
    input logic [15:0] op
  );
    use_t u;
    u = classify(op);
    return u.wr_a;
  endfunction

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  function automatic logic insn_known(
    input logic [15:0] op
  );
    return op[15] ||
      (op[14:8] inside {[7'h01:7'h15],
                        [7'h19:7'h39]});
  endfunction
`endif

endpackage

// File: rtl/cpu_scoreboard.sv
// Register busy bits for the decode interlock.
// A set and a clear of the same register in one cycle leaves it busy.
module cpu_scoreboard #(
  parameter int NREGS = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic [3:0] set_reg_i,
  input  logic       clr_i,
  input  logic [3:0] clr_reg_i,
  input  logic [3:0] rd_a_i,
  input  logic [3:0] rd_b_i,
  output logic       busy_a_o,
  output logic       busy_b_o
);

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  assign w_set = set_i ? (ONE << set_reg_i) : '0;
  assign w_clr = clr_i ? (ONE << clr_reg_i) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy_a_o = r_busy[rd_a_i];
  assign busy_b_o = r_busy[rd_b_i];

endmodule

// File: rtl/cpu_decode.sv
// mox125 decode stage: field split, pipeline register, RAW interlock.
// Define CPU_DECODE_ILLEGAL_TRAP_EN to enable illegal_o.
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] opcode_i,
  input  logic [31:0] operand_i,
  input  logic [31:0] PC_i,
  input  logic        valid_i,
  output logic        stall_o,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic        wb_valid_i,
  input  logic [3:0]  wb_reg_i,
  output logic        valid_o,
  output logic        issue_o,
  output logic [31:0] PC_o,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic [1:0]  form_o,
  output logic [3:0]  riA_o,
  output logic [3:0]  riB_o,
  output logic [31:0] imm_o,
  output logic [2:0]  insn_len_o,
  output logic [31:0] branch_target_o,
  output logic        illegal_o
);

  logic [1:0]  w_form;
  logic [3:0]  w_riA;
  logic [3:0]  w_riB;
  logic [31:0] w_sext;
  logic [31:0] w_imm;
  logic [31:0] w_target;
  logic        w_rda;
  logic        w_rdb;
  logic        w_wra;
  logic        w_illegal;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [15:0] r_opcode;
  logic [31:0] r_operand;
  logic [1:0]  r_form;
  logic [3:0]  r_riA;
  logic [3:0]  r_riB;
  logic [31:0] r_imm;
  logic [2:0]  r_len;
  logic [31:0] r_target;
  logic        r_rda;
  logic        r_rdb;
  logic        r_wra;

  logic        w_busy_a;
  logic        w_busy_b;
  logic        w_clr_a;
  logic        w_clr_b;
  logic        w_hazard;

  assign w_form   = insn_form(opcode_i);
  assign w_sext   = {{22{opcode_i[9]}}, opcode_i[9:0]};
  assign w_target = PC_i + 32'd2 + {w_sext[30:0], 1'b0};

  always_comb begin
    w_riA = 4'd0;
    w_riB = 4'd0;
    w_imm = operand_i;
    unique case (1'b1)
      (w_form == FORM2): begin
        w_riA = opcode_i[11:8];
        w_imm = {24'd0, opcode_i[7:0]};
      end
      (w_form == FORM3): begin
        w_imm = w_sext;
      end
      default: begin
        w_riA = opcode_i[7:4];
        w_riB = opcode_i[3:0];
      end
    endcase
  end

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  // Illegal opcodes never interlock.
  assign w_illegal = !insn_known(opcode_i);
  assign w_rda = reads_a(opcode_i) & !w_illegal;
  assign w_rdb = reads_b(opcode_i) & !w_illegal;
  assign w_wra = writes_a(opcode_i) & !w_illegal;

  logic r_illegal;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_illegal <= 1'b0;
    end else if (!branch_flag_i && !stall_o) begin
      r_illegal <= w_illegal;
    end
  end

  assign illegal_o = r_illegal;
`else
  assign w_illegal = 1'b0;
  assign w_rda = reads_a(opcode_i);
  assign w_rdb = reads_b(opcode_i);
  assign w_wra = writes_a(opcode_i);
  assign illegal_o = w_illegal;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_operand <= '0;
      r_form    <= '0;
      r_riA     <= '0;
      r_riB     <= '0;
      r_imm     <= '0;
      r_len     <= '0;
      r_target  <= '0;
      r_rda     <= 1'b0;
      r_rdb     <= 1'b0;
      r_wra     <= 1'b0;
    end else if (branch_flag_i) begin
      r_valid <= 1'b0;
    end else if (!stall_o) begin
      r_valid   <= valid_i;
      r_pc      <= PC_i;
      r_opcode  <= opcode_i;
      r_operand <= operand_i;
      r_form    <= w_form;
      r_riA     <= w_riA;
      r_riB     <= w_riB;
      r_imm     <= w_imm;
      r_len     <= insn_len(opcode_i);
      r_target  <= w_target;
      r_rda     <= w_rda;
      r_rdb     <= w_rdb;
      r_wra     <= w_wra;
    end
  end

  // Retiring writeback releases its register in the same cycle.
  assign w_clr_a = wb_valid_i && (wb_reg_i == r_riA);
  assign w_clr_b = wb_valid_i && (wb_reg_i == r_riB);

  assign w_hazard = r_valid &&
    ((r_rda && w_busy_a && !w_clr_a) ||
     (r_rdb && w_busy_b && !w_clr_b));

  assign issue_o = r_valid && !stall_i &&
                   !w_hazard && !branch_flag_i;
  assign stall_o = r_valid && !issue_o &&
                   !branch_flag_i;

  cpu_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (issue_o && r_wra),
    .set_reg_i(r_riA),
    .clr_i    (wb_valid_i),
    .clr_reg_i(wb_reg_i),
    .rd_a_i   (r_riA),
    .rd_b_i   (r_riB),
    .busy_a_o (w_busy_a),
    .busy_b_o (w_busy_b)
  );

  assign valid_o         = r_valid;
  assign PC_o            = r_pc;
  assign opcode_o        = r_opcode;
  assign operand_o       = r_operand;
  assign form_o          = r_form;
  assign riA_o           = r_riA;
  assign riB_o           = r_riB;
  assign imm_o           = r_imm;
  assign insn_len_o      = r_len;
  assign branch_target_o = r_target;

endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode: directed scenarios, then randomized traffic
// against a table-driven reference model of the decode stage.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] opcode_i;
  logic [31:0] operand_i;
  logic [31:0] PC_i;
  logic        valid_i;
  logic        stall_o;
  logic        stall_i;
  logic        branch_flag_i;
  logic        wb_valid_i;
  logic [3:0]  wb_reg_i;
  logic        valid_o;
  logic        issue_o;
  logic [31:0] PC_o;
  logic [15:0] opcode_o;
  logic [31:0] operand_o;
  logic [1:0]  form_o;
  logic [3:0]  riA_o;
  logic [3:0]  riB_o;
  logic [31:0] imm_o;
  logic [2:0]  insn_len_o;
  logic [31:0] branch_target_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  cpu_decode dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .opcode_i       (opcode_i),
    .operand_i      (operand_i),
    .PC_i           (PC_i),
    .valid_i        (valid_i),
    .stall_o        (stall_o),
    .stall_i        (stall_i),
    .branch_flag_i  (branch_flag_i),
    .wb_valid_i     (wb_valid_i),
    .wb_reg_i       (wb_reg_i),
    .valid_o        (valid_o),
    .issue_o        (issue_o),
    .PC_o           (PC_o),
    .opcode_o       (opcode_o),
    .operand_o      (operand_o),
    .form_o         (form_o),
    .riA_o          (riA_o),
    .riB_o          (riB_o),
    .imm_o          (imm_o),
    .insn_len_o     (insn_len_o),
    .branch_target_o(branch_target_o),
    .illegal_o      (illegal_o)
  );

  int checks = 0;
  int errors = 0;

  // usage bits: [0] reads A, [1] reads B, [2] writes A
  bit [2:0]  use_tab [128];
  bit        known_tab [128];
  int        len_tab [256];
  logic [7:0] all_ops [$];

  bit          m_v;
  logic [15:0] m_op;
  logic [31:0] m_opr;
  logic [31:0] m_pc;
  bit   [15:0] m_busy;
  bit          m_iss;
  bit          m_stl;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic mark(input logic [7:0] ops [$],
                      input bit [2:0] u);
    foreach (ops[i]) begin
      use_tab[ops[i][6:0]]   = u;
      known_tab[ops[i][6:0]] = 1'b1;
      all_ops.push_back(ops[i]);
    end
  endtask

  task automatic build_tables();
    logic [7:0] l6 [$] = '{8'h01, 8'h03, 8'h08, 8'h09,
      8'h1a, 8'h1b, 8'h1d, 8'h1f, 8'h20, 8'h22, 8'h24,
      8'h25, 8'h30};
    logic [7:0] l4 [$] = '{8'h0c, 8'h0d, 8'h36, 8'h37,
      8'h38, 8'h39};
    for (int i = 0; i < 256; i++) len_tab[i] = 2;
    for (int i = 0; i < 128; i++) begin
      use_tab[i] = 3'b000;
      known_tab[i] = 1'b0;
    end
    foreach (l6[i]) len_tab[l6[i]] = 6;
    foreach (l4[i]) len_tab[l4[i]] = 4;
    mark('{8'h03, 8'h04, 8'h0f, 8'h1a, 8'h30, 8'h35},
         3'b000);
    mark('{8'h01, 8'h08, 8'h1b, 8'h1d, 8'h20, 8'h22},
         3'b100);
    mark('{8'h02, 8'h0a, 8'h0c, 8'h10, 8'h11, 8'h12,
           8'h13, 8'h1c, 8'h21, 8'h2a, 8'h2c, 8'h36,
           8'h38}, 3'b110);
    mark('{8'h09, 8'h19, 8'h1f, 8'h24, 8'h25}, 3'b001);
    mark('{8'h0b, 8'h0d, 8'h0e, 8'h1e, 8'h23, 8'h37,
           8'h39}, 3'b011);
    mark('{8'h05, 8'h06, 8'h14, 8'h15, 8'h26, 8'h27,
           8'h28, 8'h29, 8'h2b, 8'h2d, 8'h2e, 8'h2f,
           8'h31, 8'h32, 8'h33, 8'h34}, 3'b111);
    mark('{8'h07}, 3'b101);
  endtask

  function automatic int m_form(logic [15:0] op);
    return (op < 16'h8000) ? 0 : int'(op >> 14);
  endfunction

  function automatic int sx10(logic [15:0] op);
    int s;
    s = int'(op & 16'h03ff);
    if (s >= 512) s = s - 1024;
    return s;
  endfunction

  function automatic bit m_illegal(logic [15:0] op);
`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
    return (m_form(op) == 0) && !known_tab[op[14:8]];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit [2:0] m_use(logic [15:0] op);
    int f;
    f = m_form(op);
    if (m_illegal(op)) return 3'b000;
    if (f == 0) return use_tab[op[14:8]];
    if (f == 3) return 3'b000;
    case ((op >> 12) & 3)
      0, 1:    return 3'b101;
      2:       return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic int m_ria(logic [15:0] op);
    int f;
    f = m_form(op);
    if (f == 0) return (op >> 4) & 15;
    if (f == 2) return (op >> 8) & 15;
    return 0;
  endfunction

  function automatic int m_rib(logic [15:0] op);
    return (m_form(op) == 0) ? (op & 15) : 0;
  endfunction

  task automatic settle();
    bit [2:0] u;
    int a, b;
    bit haz;
    #1;
    u = m_use(m_op);
    a = m_ria(m_op);
    b = m_rib(m_op);
    haz = m_v && (
      (u[0] && m_busy[a] &&
       !(wb_valid_i && wb_reg_i == 4'(a))) ||
      (u[1] && m_busy[b] &&
       !(wb_valid_i && wb_reg_i == 4'(b))));
    m_iss = m_v && !stall_i && !haz && !branch_flag_i;
    m_stl = m_v && !m_iss && !branch_flag_i;
    chk("valid", valid_o, m_v);
    chk("issue", issue_o, m_iss);
    chk("stall", stall_o, m_stl);
    chk("busy", dut.u_sb.r_busy, m_busy);
    if (m_v) begin
      chk("pc", PC_o, m_pc);
      chk("opcode", opcode_o, m_op);
      chk("operand", operand_o, m_opr);
      chk("form", form_o, m_form(m_op));
      chk("riA", riA_o, a);
      chk("riB", riB_o, b);
      case (m_form(m_op))
        0: chk("imm", imm_o, m_opr);
        2: chk("imm", imm_o, m_op & 16'h00ff);
        default: chk("imm", imm_o, sx10(m_op));
      endcase
      chk("len", insn_len_o, len_tab[m_op >> 8]);
      chk("target", branch_target_o,
          m_pc + 32'(2 + 2 * sx10(m_op)));
      chk("illegal", illegal_o, m_illegal(m_op));
    end
  endtask

  task automatic tick();
    bit [2:0] u;
    @(posedge clk);
    if (rst_i) begin
      m_v = 1'b0;
      m_busy = '0;
    end else begin
      u = m_use(m_op);
      if (wb_valid_i) m_busy[wb_reg_i] = 1'b0;
      if (m_iss && u[2]) m_busy[m_ria(m_op)] = 1'b1;
      if (branch_flag_i) begin
        m_v = 1'b0;
      end else if (!m_stl) begin
        m_v   = valid_i;
        m_op  = opcode_i;
        m_opr = operand_i;
        m_pc  = PC_i;
      end
    end
    #1;
  endtask

  task automatic fetch(input logic [15:0] op,
                       input logic [31:0] opr,
                       input logic [31:0] pc);
    valid_i = 1'b1;
    opcode_i = op;
    operand_i = opr;
    PC_i = pc;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    opcode_i = 16'h0;
  endtask

  initial begin
    logic [15:0] busy_snap;
    build_tables();
    m_v = 0; m_op = 0; m_opr = 0; m_pc = 0;
    m_busy = 0; m_iss = 0; m_stl = 0;
    rst_i = 1'b1;
    valid_i = 0; opcode_i = 0; operand_i = 0; PC_i = 0;
    stall_i = 0; branch_flag_i = 0;
    wb_valid_i = 0; wb_reg_i = 0;
    tick();
    tick();
    rst_i = 1'b0;
    settle();
    chk("rst_valid", valid_o, 0);
    chk("rst_issue", issue_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_pc", PC_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_target", branch_target_o, 0);
    chk("rst_len", insn_len_o, 0);
    chk("rst_busy", dut.u_sb.r_busy, 0);

    // mov $r1,$r2 issues and marks r1 busy
    fetch(16'h0212, 32'h0, 32'h1000);
    settle(); tick();
    fetch(16'h0531, 32'h0, 32'h1002);
    settle();
    chk("mov_valid", valid_o, 1);
    chk("mov_form", form_o, 0);
    chk("mov_riA", riA_o, 1);
    chk("mov_riB", riB_o, 2);
    chk("mov_len", insn_len_o, 2);
    chk("mov_issue", issue_o, 1);
    tick();
    chk("mov_busy1", dut.u_sb.r_busy[1], 1);
    // add.l $r3,$r1 interlocks until r1 retires
    idle();
    settle();
    chk("add_stall", stall_o, 1);
    chk("add_noissue", issue_o, 0);
    tick();
    settle();
    chk("add_hold", opcode_o, 16'h0531);
    wb_valid_i = 1'b1; wb_reg_i = 4'd1;
    settle();
    chk("add_bypass_issue", issue_o, 1);
    chk("add_bypass_stall", stall_o, 0);
    tick();
    wb_valid_i = 1'b0;

    fetch(16'hC3FE, 32'h0, 32'h2000);
    settle(); tick(); idle(); settle();
    chk("f3_form", form_o, 3);
    chk("f3_imm", imm_o, 32'hFFFFFFFE);
    chk("f3_target", branch_target_o, 32'h1FFE);
    tick();

    fetch(16'h0100, 32'hDEADBEEF, 32'h2002);
    settle(); tick(); idle(); settle();
    chk("ldi_len", insn_len_o, 6);
    chk("ldi_imm", imm_o, 32'hDEADBEEF);
    tick();

    // flush of a stalled instruction keeps busy bits
    fetch(16'h0212, 32'h0, 32'h3000);
    settle(); tick();
    fetch(16'h0531, 32'h0, 32'h3002);
    settle(); tick(); idle(); settle();
    chk("fl_stall", stall_o, 1);
    branch_flag_i = 1'b1;
    settle();
    chk("fl_issue", issue_o, 0);
    chk("fl_stall_drop", stall_o, 0);
    busy_snap = dut.u_sb.r_busy;
    tick();
    branch_flag_i = 1'b0;
    settle();
    chk("fl_valid", valid_o, 0);
    chk("fl_busy", dut.u_sb.r_busy, busy_snap);
    chk("fl_busy1", busy_snap[1], 1);
    tick();

    fetch(16'h4000, 32'h0, 32'h4000);
    settle(); tick(); idle(); settle();
`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", illegal_o, 1);
`else
    chk("ill_flag", illegal_o, 0);
`endif
    chk("ill_nostall", stall_o, 0);
    tick();

    // reset while stalled
    fetch(16'h0531, 32'h0, 32'h5000);
    settle(); tick(); idle(); settle();
    chk("rs_stall", stall_o, 1);
    rst_i = 1'b1;
    settle(); tick();
    rst_i = 1'b0;
    settle();
    chk("rs_stall_drop", stall_o, 0);
    chk("rs_valid", valid_o, 0);
    chk("rs_busy", dut.u_sb.r_busy, 0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      int r;
      if (!m_stl) begin
        r = $urandom_range(0, 99);
        if (r < 55)
          opcode_i = {all_ops[$urandom_range(0,
                        all_ops.size() - 1)],
                      4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3))};
        else if (r < 65)
          opcode_i = {1'b0, 7'($urandom), 8'($urandom)};
        else if (r < 82)
          opcode_i = {2'b10, 2'($urandom),
                      4'($urandom_range(0, 3)),
                      8'($urandom)};
        else
          opcode_i = {2'b11, 14'($urandom)};
        operand_i = $urandom;
        PC_i = {$urandom, 1'b0};
        valid_i = ($urandom_range(0, 99) < 85);
      end
      stall_i = ($urandom_range(0, 99) < 20);
      branch_flag_i = ($urandom_range(0, 99) < 5);
      wb_valid_i = ($urandom_range(0, 99) < 40);
      wb_reg_i = $urandom_range(0, 1) ?
        4'($urandom_range(0, 3)) : 4'($urandom);
      rst_i = ($urandom_range(0, 999) < 3);
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
